// File: rtl/rotate_pkg.sv
// rtl/rotate_pkg.sv - shared types and constants for the rotate sequencer
// Contents:
//   state_t        : sequencer states IDLE, ROTATE, FINISH
//   ROT_DEFAULT_N  : default data word width

package rotate_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int ROT_DEFAULT_N = 8;

endpackage

// File: rtl/rotateN.sv
// rtl/rotateN.sv - combinational one-bit N-bit rotator
// Ports:
//   din  in  N  word to rotate
//   dir  in  1  0 = rotate left, 1 = rotate right
//   dout out N  din rotated by one position, no bit lost

module rotateN #(
  parameter int N = 8
) (
  input  logic [N-1:0] din,
  input  logic         dir,
  output logic [N-1:0] dout
);

  // Left: MSB wraps into bit 0. Right: LSB wraps into the MSB.
  assign dout = dir ? {din[0], din[N-1:1]} : {din[N-2:0], din[N-1]};

endmodule

// File: rtl/rotate_seq_ctrl.sv
// rtl/rotate_seq_ctrl.sv - multi-cycle rotate sequencer, one bit per clock
// Ports:
//   CLK    in  1   clock, rising edge
//   RESET  in  1   synchronous active-high reset
//   START  in  1   request a rotation (accepted only in IDLE)
//   ABORT  in  1   cancel a rotation in progress (ROTATE only)
//   DIN    in  N   word to rotate, captured on the accepting edge
//   DIR    in  1   0 = left, 1 = right, captured with DIN
//   COUNT  in  CW  number of one-bit rotations, captured with DIN
//   DOUT   out N   working register
//   BUSY   out 1   high while rotating
//   DONE   out 1   one-cycle completion pulse

module rotate_seq_ctrl
  import rotate_pkg::*;
#(
  parameter int N  = ROT_DEFAULT_N,
  parameter int CW = $clog2(N)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          START,
  input  logic          ABORT,
  input  logic [N-1:0]  DIN,
  input  logic          DIR,
  input  logic [CW-1:0] COUNT,
  output logic [N-1:0]  DOUT,
  output logic          BUSY,
  output logic          DONE
);

  state_t        state;
  state_t        state_next;
  logic [N-1:0]  work_q;
  logic [N-1:0]  rot_w;
  logic [CW-1:0] cnt_q;
  logic          dir_q;
  logic          load;
  logic          step;

  rotateN #(.N(N)) u_rot (
    .din  (work_q),
    .dir  (dir_q),
    .dout (rot_w)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        // ABORT has no meaning here; START alone decides.
        if (START) begin
          load       = 1'b1;
          state_next = (COUNT != '0) ? ROTATE : FINISH;
        end
      end
      ROTATE: begin
        // An abort edge does not rotate: the word stays as it was.
        if (ABORT) begin
          state_next = IDLE;
        end else begin
          step = 1'b1;
          if (cnt_q == CW'(1)) begin
            state_next = FINISH;
          end
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      work_q <= '0;
      cnt_q  <= '0;
      dir_q  <= 1'b0;
    end else if (load) begin
      work_q <= DIN;
      cnt_q  <= COUNT;
      dir_q  <= DIR;
    end else if (step) begin
      work_q <= rot_w;
      cnt_q  <= cnt_q - CW'(1);
    end
  end

  assign DOUT = work_q;
  assign BUSY = (state == ROTATE);
  assign DONE = (state == FINISH);

endmodule

// File: tb/tb_rotate_seq_ctrl.sv
// tb/tb_rotate_seq_ctrl.sv - directed self-checking bench for rotate_seq_ctrl

module tb_rotate_seq_ctrl;

  logic       CLK;
  logic       RESET;
  logic       START;
  logic       ABORT;
  logic [7:0] DIN;
  logic       DIR;
  logic [2:0] COUNT;
  logic [7:0] DOUT;
  logic       BUSY;
  logic       DONE;

  int n_checks = 0;
  int n_pass   = 0;

  rotate_seq_ctrl #(.N(8), .CW(3)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .START (START),
    .ABORT (ABORT),
    .DIN   (DIN),
    .DIR   (DIR),
    .COUNT (COUNT),
    .DOUT  (DOUT),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one rotation and follow it to DONE; inputs change on negedges.
  task automatic do_rot(input string tag, input logic [7:0] d, input logic dr,
                        input logic [2:0] c, input logic ab, input logic [7:0] exp);
    int busy_n;
    int guard;
    START = 1'b1;
    ABORT = ab;
    DIN   = d;
    DIR   = dr;
    COUNT = c;
    @(posedge CLK);
    @(negedge CLK);
    START  = 1'b0;
    ABORT  = 1'b0;
    busy_n = 0;
    guard  = 0;
    while (!DONE && guard < 20) begin
      if (BUSY) busy_n++;
      guard++;
      @(negedge CLK);
    end
    check({tag, "_done"}, 32'(DONE), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(c));
    check({tag, "_busy_in_finish"}, 32'(BUSY), 32'd0);
    check({tag, "_dout"}, 32'(DOUT), 32'(exp));
    @(negedge CLK);
    check({tag, "_done_one_cycle"}, 32'(DONE), 32'd0);
    check({tag, "_dout_held"}, 32'(DOUT), 32'(exp));
  endtask

  initial begin
    int done_seen;
    RESET = 1'b1;
    START = 1'b0;
    ABORT = 1'b0;
    DIN   = 8'h00;
    DIR   = 1'b0;
    COUNT = 3'd0;
    repeat (2) @(negedge CLK);
    check("reset_dout", 32'(DOUT), 32'd0);
    check("reset_busy", 32'(BUSY), 32'd0);
    check("reset_done", 32'(DONE), 32'd0);
    RESET = 1'b0;
    @(negedge CLK);

    do_rot("rotl3", 8'b10101100, 1'b0, 3'd3, 1'b0, 8'b01100101);
    do_rot("rotr2", 8'b10101100, 1'b1, 3'd2, 1'b0, 8'b00101011);
    do_rot("zero",  8'b10101100, 1'b0, 3'd0, 1'b0, 8'b10101100);
    do_rot("rotl7", 8'b10101100, 1'b0, 3'd7, 1'b0, 8'b01010110);
    do_rot("rotr7", 8'b10101100, 1'b1, 3'd7, 1'b0, 8'b01011001);
    // START with ABORT in IDLE still starts.
    do_rot("abort_idle", 8'b10000001, 1'b0, 3'd1, 1'b1, 8'b00000011);

    // Abort after two rotate edges; a mid-rotation START is ignored.
    START = 1'b1; DIN = 8'b10101100; DIR = 1'b0; COUNT = 3'd5;
    @(posedge CLK); @(negedge CLK);
    START = 1'b1; DIN = 8'hFF; DIR = 1'b1; COUNT = 3'd1;
    check("abort_busy", 32'(BUSY), 32'd1);
    @(posedge CLK); @(negedge CLK);
    START = 1'b0;
    check("abort_rot1", 32'(DOUT), 32'b01011001);
    @(posedge CLK); @(negedge CLK);
    check("abort_rot2", 32'(DOUT), 32'b10110010);
    ABORT = 1'b1;
    @(posedge CLK); @(negedge CLK);
    ABORT = 1'b0;
    check("abort_idle_busy", 32'(BUSY), 32'd0);
    check("abort_no_done", 32'(DONE), 32'd0);
    check("abort_dout", 32'(DOUT), 32'b10110010);
    done_seen = 0;
    repeat (6) begin
      @(negedge CLK);
      if (DONE) done_seen++;
    end
    check("abort_no_done_later", 32'(done_seen), 32'd0);
    check("abort_dout_held", 32'(DOUT), 32'b10110010);

    // Reset in the middle of a rotation.
    START = 1'b1; DIN = 8'b10101100; DIR = 1'b1; COUNT = 3'd6;
    @(posedge CLK); @(negedge CLK);
    START = 1'b0;
    @(posedge CLK); @(negedge CLK);
    check("rst_mid_busy_before", 32'(BUSY), 32'd1);
    RESET = 1'b1; START = 1'b1; ABORT = 1'b1;
    @(posedge CLK); @(negedge CLK);
    check("rst_mid_dout", 32'(DOUT), 32'd0);
    check("rst_mid_busy", 32'(BUSY), 32'd0);
    check("rst_mid_done", 32'(DONE), 32'd0);
    RESET = 1'b0; START = 1'b0; ABORT = 1'b0;
    done_seen = 0;
    repeat (10) begin
      @(negedge CLK);
      if (DONE) done_seen++;
    end
    check("rst_mid_no_done", 32'(done_seen), 32'd0);
    check("rst_mid_dout_held", 32'(DOUT), 32'd0);

    // Back-to-back with START held; second job uses DIN at the IDLE edge.
    START = 1'b1; DIN = 8'b10101100; DIR = 1'b0; COUNT = 3'd1;
    @(posedge CLK); @(negedge CLK);
    DIN = 8'h0F; DIR = 1'b1; COUNT = 3'd2;
    check("b2b_first_busy", 32'(BUSY), 32'd1);
    @(posedge CLK); @(negedge CLK);
    check("b2b_first_done", 32'(DONE), 32'd1);
    check("b2b_first_dout", 32'(DOUT), 32'b01011001);
    @(posedge CLK); @(negedge CLK);
    check("b2b_idle_busy", 32'(BUSY), 32'd0);
    check("b2b_idle_done", 32'(DONE), 32'd0);
    check("b2b_idle_dout", 32'(DOUT), 32'b01011001);
    @(posedge CLK); @(negedge CLK);
    START = 1'b0;
    check("b2b_second_busy", 32'(BUSY), 32'd1);
    check("b2b_second_load", 32'(DOUT), 32'h0F);
    @(posedge CLK); @(negedge CLK);
    check("b2b_second_step1", 32'(DOUT), 32'h87);
    @(posedge CLK); @(negedge CLK);
    check("b2b_second_done", 32'(DONE), 32'd1);
    check("b2b_second_dout", 32'(DOUT), 32'hC3);
    @(posedge CLK); @(negedge CLK);
    check("b2b_end_idle", 32'(BUSY | DONE), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
